decodificador_teclado_nxm: RTL and testbench

DECODIFICADOR_TECLADO_NXM -- requirements
Module: decodificador_teclado_nxm

---
 rtl/teclado_pkg.sv | 23 ++
 rtl/fifo_sync.sv | 58 +++++
 rtl/decodificador_teclado_nxm.sv | 227 ++++++++++++++++++++++
 tb/tb_decodificador_teclado_nxm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared state type and width helpers for the keypad matrix decoder
package teclado_pkg;

    typedef enum logic [2:0] {
        VARRE    = 3'd0,
        DEBOUNCE = 3'd1,
        EMITE    = 3'd2,
        SEGURA   = 3'd3,
        SOLTA    = 3'd4
    } estado_t;

    function automatic int calc_kw(input int n_lin, input int n_col);
        int n;
        n = n_lin * n_col;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold values 0..max_val.
    function automatic int largura(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - synchronous FIFO; a push into a full FIFO succeeds only alongside a pop
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/decodificador_teclado_nxm.sv
// rtl/decodificador_teclado_nxm.sv - scanned NxM keypad decoder with debounce, auto-repeat and event FIFO
module decodificador_teclado_nxm
    import teclado_pkg::*;
#(
    parameter int N_LIN          = 4,
    parameter int N_COL          = 4,
    parameter int SCAN_CICLOS    = 8,
    parameter int DEBOUNCE_P     = 100,
    parameter int REPEAT_ATRASO  = 5000,
    parameter int REPEAT_PERIODO = 1000,
    parameter int FIFO_PROF      = 4,
    localparam int KW            = calc_kw(N_LIN, N_COL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_COL-1:0] col_matriz,
    output logic [N_LIN-1:0] lin_matriz,
    output logic [KW-1:0]    tecla_value,
    output logic             tecla_repeat,
    output logic             tecla_valid,
    input  logic             tecla_ready,
    output logic             tecla_multi,
    output logic             fifo_ovf
);
    localparam int LW   = largura(N_LIN - 1);
    localparam int CW   = largura(N_COL - 1);
    localparam int NBW  = largura(N_COL);
    localparam int SW   = largura(SCAN_CICLOS - 1);
    localparam int DW   = largura(DEBOUNCE_P);
    localparam int RMAX = (REPEAT_ATRASO > REPEAT_PERIODO) ? REPEAT_ATRASO : REPEAT_PERIODO;
    localparam int RW   = largura(RMAX);
    localparam int ARW  = largura(N_LIN);
    localparam int ATRASO_M1 = (REPEAT_ATRASO > 0) ? REPEAT_ATRASO - 1 : 0;

    estado_t          estado_q, estado_d;
    logic [LW-1:0]    lin_q, lin_d, lin_prox;
    logic [SW-1:0]    scan_q, scan_d;
    logic [CW-1:0]    col_q, col_d;
    logic [DW-1:0]    deb_q, deb_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
    logic [ARW-1:0]   limpo_q, limpo_d;
    logic             armado_q, armado_d;
    logic             multi_q, multi_d;
    logic             ovf_q, ovf_d;

    logic [N_COL-1:0] baixas;
    logic [NBW-1:0]   n_baixas;
    logic [CW-1:0]    col_baixa;
    logic             so_latched, latched_alta, todas_altas;
    logic [KW-1:0]    idx;
    logic             push, push_rep, pop, full, empty;
    logic [KW:0]      fifo_rd;

    always_comb begin
        baixas    = ~col_matriz;
        n_baixas  = '0;
        col_baixa = '0;
        for (int c = 0; c < N_COL; c++) begin
            if (baixas[c]) begin
                n_baixas  = n_baixas + 1'b1;
                col_baixa = CW'(c);
            end
        end
    end

    assign so_latched   = (baixas == (N_COL'(1) << col_q));
    assign latched_alta = col_matriz[col_q];
    assign todas_altas  = &col_matriz;
    assign lin_prox     = (lin_q == LW'(N_LIN - 1)) ? '0 : lin_q + 1'b1;
    assign idx          = KW'(lin_q) * KW'(N_COL) + KW'(col_q);

    always_comb begin
        estado_d    = estado_q;
        lin_d       = lin_q;
        scan_d      = scan_q;
        col_d       = col_q;
        deb_d       = deb_q;
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        limpo_d     = limpo_q;
        armado_d    = armado_q;
        multi_d     = 1'b0;
        push        = 1'b0;
        push_rep    = 1'b0;
        case (estado_q)
            VARRE: begin
                if (scan_q == SW'(SCAN_CICLOS - 1)) begin
                    scan_d = '0;
                    lin_d  = lin_prox;
                    // Presses are ignored until one full clean pass after reset, so a key held through reset never emits.
                    if (n_baixas == '0) begin
                        if (!armado_q) begin
                            if (limpo_q == ARW'(N_LIN - 1)) begin
                                armado_d = 1'b1;
                            end else begin
                                limpo_d = limpo_q + 1'b1;
                            end
                        end
                    end else begin
                        limpo_d = '0;
                        if (armado_q) begin
                            if (n_baixas == NBW'(1)) begin
                                lin_d    = lin_q;
                                col_d    = col_baixa;
                                deb_d    = '0;
                                estado_d = DEBOUNCE;
                            end else begin
                                multi_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (so_latched) begin
                    if (deb_q == DW'(DEBOUNCE_P - 1)) begin
                        deb_d    = '0;
                        estado_d = EMITE;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d    = '0;
                    lin_d    = lin_prox;
                    estado_d = VARRE;
                end
            end
            EMITE: begin
                push        = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b0;
                estado_d    = SEGURA;
            end
            SEGURA: begin
                if (latched_alta) begin
                    deb_d    = '0;
                    estado_d = SOLTA;
                end else if (REPEAT_ATRASO != 0) begin
                    if (rep_q == (rep_first_q ? RW'(REPEAT_PERIODO - 1) : RW'(ATRASO_M1))) begin
                        push        = 1'b1;
                        push_rep    = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
            end
            SOLTA: begin
                if (todas_altas) begin
                    if (deb_q == DW'(DEBOUNCE_P - 1)) begin
                        deb_d    = '0;
                        scan_d   = '0;
                        lin_d    = lin_prox;
                        estado_d = VARRE;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d       = '0;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                    estado_d    = SEGURA;
                end
            end
            default: begin
                estado_d = VARRE;
            end
        endcase
    end

    assign pop   = !empty && tecla_ready;
    assign ovf_d = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= VARRE;
            lin_q       <= '0;
            scan_q      <= '0;
            col_q       <= '0;
            deb_q       <= '0;
            rep_q       <= '0;
            rep_first_q <= 1'b0;
            limpo_q     <= '0;
            armado_q    <= 1'b0;
            multi_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            lin_q       <= lin_d;
            scan_q      <= scan_d;
            col_q       <= col_d;
            deb_q       <= deb_d;
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
            limpo_q     <= limpo_d;
            armado_q    <= armado_d;
            multi_q     <= multi_d;
            ovf_q       <= ovf_d;
        end
    end

    fifo_sync #(
        .WIDTH (KW + 1),
        .DEPTH (FIFO_PROF)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({push_rep, idx}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (empty)
    );

    assign lin_matriz   = ~(N_LIN'(1) << lin_q);
    assign tecla_valid  = !empty;
    assign tecla_value  = empty ? '1 : fifo_rd[KW-1:0];
    assign tecla_repeat = !empty && fifo_rd[KW];
    assign tecla_multi  = multi_q;
    assign fifo_ovf     = ovf_q;

endmodule

// File: tb/tb_decodificador_teclado_nxm.sv
// tb/tb_decodificador_teclado_nxm.sv - scoreboard bench for the keypad decoder (4x4 and 3x5 instances)
module tb_decodificador_teclado_nxm;

    localparam int A_LIN = 4, A_COL = 4, A_SCAN = 8, A_DEB = 100, A_ATR = 200, A_PER = 50, A_PROF = 2;
    localparam int B_LIN = 3, B_COL = 5, B_SCAN = 4, B_DEB = 20, B_ATR = 300, B_PER = 40, B_PROF = 4;
    localparam int KW = 4;

    typedef struct {
        int val;
        bit rep;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    logic rst_a_n, rst_b_n;
    logic [A_COL-1:0] col_a;
    logic [A_LIN-1:0] lin_a;
    logic [KW-1:0]    val_a;
    logic             rep_a, valid_a, ready_a, multi_a, ovf_a;
    logic [A_LIN*A_COL-1:0] keys_a;
    int               rmode_a;

    logic [B_COL-1:0] col_b;
    logic [B_LIN-1:0] lin_b;
    logic [KW-1:0]    val_b;
    logic             rep_b, valid_b, ready_b, multi_b, ovf_b;
    logic [B_LIN*B_COL-1:0] keys_b;

    ent_t exp_a[$];
    ent_t exp_b[$];
    int   pop_t_a[$];
    int   n_multi_a = 0, n_ovf_a = 0, n_multi_b = 0, n_ovf_b = 0;
    logic prev_valid_a = 1'b0, prev_valid_b = 1'b0;

    decodificador_teclado_nxm #(
        .N_LIN(A_LIN), .N_COL(A_COL), .SCAN_CICLOS(A_SCAN), .DEBOUNCE_P(A_DEB),
        .REPEAT_ATRASO(A_ATR), .REPEAT_PERIODO(A_PER), .FIFO_PROF(A_PROF)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .col_matriz(col_a), .lin_matriz(lin_a),
        .tecla_value(val_a), .tecla_repeat(rep_a), .tecla_valid(valid_a),
        .tecla_ready(ready_a), .tecla_multi(multi_a), .fifo_ovf(ovf_a)
    );

    decodificador_teclado_nxm #(
        .N_LIN(B_LIN), .N_COL(B_COL), .SCAN_CICLOS(B_SCAN), .DEBOUNCE_P(B_DEB),
        .REPEAT_ATRASO(B_ATR), .REPEAT_PERIODO(B_PER), .FIFO_PROF(B_PROF)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .col_matriz(col_b), .lin_matriz(lin_b),
        .tecla_value(val_b), .tecla_repeat(rep_b), .tecla_valid(valid_b),
        .tecla_ready(ready_b), .tecla_multi(multi_b), .fifo_ovf(ovf_b)
    );

    // Physical keypad: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col_a = '1;
        for (int r = 0; r < A_LIN; r++)
            for (int c = 0; c < A_COL; c++)
                if (!lin_a[r] && keys_a[r*A_COL+c]) col_a[c] = 1'b0;
    end

    always_comb begin
        col_b = '1;
        for (int r = 0; r < B_LIN; r++)
            for (int c = 0; c < B_COL; c++)
                if (!lin_b[r] && keys_b[r*B_COL+c]) col_b[c] = 1'b0;
    end

    task automatic chk(input string nome, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, act, req, cycle);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Auto-repeat events produced by a key held h clocks past its first event.
    function automatic int n_rep(input int h, input int atr, input int per);
        if (atr == 0 || h <= atr) return 0;
        return 1 + (h - atr - 1) / per;
    endfunction

    // Detection lag is unknown within one scan pass, so pick holds whose repeat count is the same across that window.
    function automatic int pick_hold(input bit inst);
        int deb, lag, atr, per, lo, h;
        deb = inst ? B_DEB : A_DEB;
        lag = inst ? B_LIN * B_SCAN : A_LIN * A_SCAN;
        atr = inst ? B_ATR : A_ATR;
        per = inst ? B_PER : A_PER;
        lo  = deb + lag + 10;
        for (int t = 0; t < 100; t++) begin
            h = $urandom_range(lo, 420);
            if (n_rep(h - deb - lag - 5, atr, per) == n_rep(h - deb + 3, atr, per)) return h;
        end
        return lo;
    endfunction

    task automatic press(input bit inst, input int k, input int hold, input bit expect_it);
        int deb, lag, atr, per, nr;
        ent_t e;
        deb = inst ? B_DEB : A_DEB;
        lag = inst ? B_LIN * B_SCAN : A_LIN * A_SCAN;
        atr = inst ? B_ATR : A_ATR;
        per = inst ? B_PER : A_PER;
        nr  = n_rep(hold - deb - lag - 2, atr, per);
        if (expect_it) begin
            e.val = k;
            for (int i = 0; i <= nr; i++) begin
                e.rep = (i != 0);
                if (inst) exp_b.push_back(e);
                else exp_a.push_back(e);
            end
        end
        if (inst) keys_b[k] = 1'b1;
        else keys_a[k] = 1'b1;
        wait_cyc(hold);
        if (inst) keys_b[k] = 1'b0;
        else keys_a[k] = 1'b0;
        wait_cyc(deb + 20);
    endtask

    initial begin
        ready_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready_a = (rmode_a == 2) ? 1'($urandom_range(0, 1)) : (rmode_a == 1);
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (rst_a_n) begin
            if (multi_a) n_multi_a++;
            if (ovf_a) n_ovf_a++;
            if (valid_a && ready_a) begin
                pop_t_a.push_back(cycle);
                if (exp_a.size() == 0) chk("a_unexpected_entry", int'(val_a), -1);
                else begin
                    e = exp_a.pop_front();
                    chk("a_value", int'(val_a), e.val);
                    chk("a_repeat", int'(rep_a), int'(e.rep));
                end
            end
            if (!valid_a && prev_valid_a) begin
                chk("a_empty_value", int'(val_a), 15);
                chk("a_empty_repeat", int'(rep_a), 0);
            end
        end
        prev_valid_a = valid_a;
    end

    always @(negedge clk) begin
        ent_t e;
        if (rst_b_n) begin
            if (multi_b) n_multi_b++;
            if (ovf_b) n_ovf_b++;
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) chk("b_unexpected_entry", int'(val_b), -1);
                else begin
                    e = exp_b.pop_front();
                    chk("b_value", int'(val_b), e.val);
                    chk("b_repeat", int'(rep_b), int'(e.rep));
                end
            end
            if (!valid_b && prev_valid_b) chk("b_empty_value", int'(val_b), 15);
        end
        prev_valid_b = valid_b;
    end

    initial begin
        logic [A_LIN-1:0] l0;
        int m0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        keys_a  = '0;
        keys_b  = '0;
        rmode_a = 1;
        ready_b = 1'b1;
        wait_cyc(3);
        chk("a_rst_valid", int'(valid_a), 0);
        chk("a_rst_value", int'(val_a), 15);
        chk("a_rst_repeat", int'(rep_a), 0);
        chk("a_rst_multi", int'(multi_a), 0);
        chk("a_rst_ovf", int'(ovf_a), 0);
        chk("a_rst_lin", int'(lin_a), 4'b1110);
        chk("b_rst_valid", int'(valid_b), 0);
        chk("b_rst_lin", int'(lin_b), 3'b110);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        wait_cyc(100);

        pop_t_a.delete();
        press(0, 2 * A_COL + 1, 150, 1);
        chk("a_single_count", pop_t_a.size(), 1);
        l0 = lin_a;
        wait_cyc(A_SCAN);
        chk("a_scan_after_release", int'(lin_a != l0), 1);

        pop_t_a.delete();
        press(0, 5, A_DEB + 395, 1);
        chk("a_repeat_count", pop_t_a.size(), 5);
        if (pop_t_a.size() == 5) begin
            chk("a_first_repeat_gap", pop_t_a[1] - pop_t_a[0], A_ATR);
            for (int i = 2; i < 5; i++) chk("a_repeat_period", pop_t_a[i] - pop_t_a[i-1], A_PER);
        end

        pop_t_a.delete();
        keys_a[0] = 1'b1;
        wait_cyc(50);
        keys_a[0] = 1'b0;
        wait_cyc(150);
        chk("a_glitch_entries", pop_t_a.size(), 0);
        l0 = lin_a;
        wait_cyc(A_SCAN);
        chk("a_scan_after_glitch", int'(lin_a != l0), 1);

        m0 = n_multi_a;
        keys_a[1*A_COL+0] = 1'b1;
        keys_a[1*A_COL+3] = 1'b1;
        wait_cyc(150);
        keys_a = '0;
        wait_cyc(150);
        chk("a_multi_pulsed", int'(n_multi_a > m0), 1);

        rmode_a = 2;
        for (int i = 0; i < 8; i++) press(0, $urandom_range(0, 15), pick_hold(0), 1);
        rmode_a = 1;
        wait_cyc(20);
        chk("a_random_drained", exp_a.size(), 0);

        rmode_a = 0;
        wait_cyc(2);
        press(0, 3, 170, 1);
        press(0, 10, 170, 1);
        press(0, 12, 170, 0);
        chk("a_full_valid", int'(valid_a), 1);
        chk("a_full_head", int'(val_a), 3);
        chk("a_ovf_pulses", n_ovf_a, 1);
        rmode_a = 1;
        wait_cyc(10);
        chk("a_drained_in_order", exp_a.size(), 0);

        begin
            ent_t e;
            e.val = 2 * B_COL + 4;
            e.rep = 1'b0;
            exp_b.push_back(e);
        end
        keys_b[2*B_COL+4] = 1'b1;
        wait_cyc(B_DEB + B_LIN * B_SCAN + 40);
        chk("b_value14_seen", exp_b.size(), 0);
        rst_b_n = 1'b0;
        #2;
        chk("b_midreset_valid", int'(valid_b), 0);
        chk("b_midreset_value", int'(val_b), 15);
        chk("b_midreset_lin", int'(lin_b), 3'b110);
        wait_cyc(3);
        rst_b_n = 1'b1;
        wait_cyc(400);
        keys_b = '0;
        wait_cyc(B_DEB + 50);
        press(1, 2 * B_COL + 4, 80, 1);
        for (int i = 0; i < 5; i++) press(1, $urandom_range(0, 14), pick_hold(1), 1);
        wait_cyc(20);

        chk("a_queue_empty", exp_a.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);
        chk("a_ovf_total", n_ovf_a, 1);
        chk("b_ovf_total", n_ovf_b, 0);
        chk("b_multi_total", n_multi_b, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
